// File: rtl/p4s1_burst_if.sv
// p4s1_burst_if: parallel-load / serial-out bus for the p4s1_burst stage.
interface p4s1_burst_if #(parameter int WORDLENGTH = 16);
    logic                  enable;
    logic                  load;
    logic [WORDLENGTH-1:0] data_in0;
    logic [WORDLENGTH-1:0] data_in1;
    logic [WORDLENGTH-1:0] data_in2;
    logic [WORDLENGTH-1:0] data_in3;
    logic                  ready;
    logic [WORDLENGTH-1:0] data_out;
    logic                  valid_out;
    logic [1:0]            slot_out;
    modport master (
        output enable, load, data_in0, data_in1, data_in2, data_in3,
        input  ready, data_out, valid_out, slot_out
    );
    modport slave (
        input  enable, load, data_in0, data_in1, data_in2, data_in3,
        output ready, data_out, valid_out, slot_out
    );
endinterface

// File: rtl/p4s1_burst.sv
// p4s1_burst: 4-to-1 parallel-to-serial stage, data_in3 first; P4S1_OVERRUN_EN adds a sticky overrun flag.
module p4s1_burst #(
    parameter int WORDLENGTH = 16
) (
    input logic          clk,
    input logic          rst,
    p4s1_burst_if.slave  bus
`ifdef P4S1_OVERRUN_EN
    ,
    input  logic         clr_ovr,
    output logic         overrun
`endif
);
    typedef enum logic {IDLE, SHIFT} state_e;
    state_e                         state_q, state_d;
    logic [1:0]                     cnt_q, cnt_d, slot_q, slot_d;
    logic [2:0][WORDLENGTH-1:0]     sh_q, sh_d;
    logic [WORDLENGTH-1:0]          data_q, data_d;
    logic                           valid_q, valid_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (bus.enable)
            state_d = (state_q == IDLE) ? (bus.load ? SHIFT : IDLE) : (cnt_q == 2'd3 ? IDLE : SHIFT);
    end
    // sh[2] is always the next word to emit; cnt wraps 3->0 on the final word
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        if (bus.enable && state_q == SHIFT) begin
            data_d  = sh_q[2];
            sh_d    = {sh_q[1:0], {WORDLENGTH{1'b0}}};
            slot_d  = ~cnt_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 2'd1;
        end else if (bus.enable && bus.load) begin
            data_d  = bus.data_in3;
            sh_d    = {bus.data_in2, bus.data_in1, bus.data_in0};
            slot_d  = 2'd3;
            valid_d = 1'b1;
            cnt_d   = 2'd1;
        end else if (bus.enable) begin
            valid_d = 1'b0;
        end
    end
    assign bus.ready     = (state_q == IDLE);
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.slot_out  = slot_q;
`ifdef P4S1_OVERRUN_EN
    logic ovr_q, ovr_d;
    always_comb
        ovr_d = (bus.enable && bus.load && state_q != IDLE) ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovr_q <= 1'b0;
        else      ovr_q <= ovr_d;
    end
    assign overrun = ovr_q;
`endif
endmodule

// File: tb/tb_p4s1_burst.sv
// tb_p4s1_burst: directed stimulus with a scoreboard of expected {slot, word} pairs.
module tb_p4s1_burst;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    p4s1_burst_if #(.WORDLENGTH(W)) bus ();
`ifdef P4S1_OVERRUN_EN
    logic clr_ovr = 1'b0;
    logic overrun;
`endif
    p4s1_burst #(.WORDLENGTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef P4S1_OVERRUN_EN
        ,
        .clr_ovr(clr_ovr),
        .overrun(overrun)
`endif
    );
    int pass_cnt = 0;
    int total = 0;
    logic [W+1:0] sb[$];
    logic [W+1:0] exp_w;
    logic en_edge = 1'b0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic ld, input logic [W-1:0] a0, a1, a2, a3);
        bus.load = ld;
        bus.data_in0 = a0;
        bus.data_in1 = a1;
        bus.data_in2 = a2;
        bus.data_in3 = a3;
    endtask
    task automatic push(input logic [W-1:0] a0, a1, a2, a3);
        sb.push_back({2'd3, a3});
        sb.push_back({2'd2, a2});
        sb.push_back({2'd1, a1});
        sb.push_back({2'd0, a0});
    endtask
    always @(posedge clk) en_edge = bus.enable;
    always @(negedge clk) begin
        if (rst && bus.valid_out && en_edge) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_word: got 0x%0h slot %0d, expected no word", bus.data_out, bus.slot_out);
            end else begin
                exp_w = sb.pop_front();
                chk("serial_word", {14'd0, bus.slot_out, bus.data_out}, {14'd0, exp_w});
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end
    initial begin
        bus.enable = 1'b1;
        drive(1'b1, 16'h1, 16'h2, 16'h3, 16'h4);
        step();
        step();
        chk("reset_data", bus.data_out, 0);
        chk("reset_valid", bus.valid_out, 0);
        chk("reset_slot", bus.slot_out, 0);
        chk("reset_ready", bus.ready, 1);
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        chk("post_reset_valid", bus.valid_out, 0);
        chk("post_reset_data", bus.data_out, 0);
        chk("post_reset_slot", bus.slot_out, 0);
        // single burst
        drive(1'b1, 16'h1, 16'h2, 16'h3, 16'h4);
        push(16'h1, 16'h2, 16'h3, 16'h4);
        chk("burst_ready_high", bus.ready, 1);
        step();
        chk("burst_ready_low", bus.ready, 0);
        chk("burst_first_word", bus.data_out, 16'h4);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) step();
        chk("burst_last_slot", bus.slot_out, 0);
        step();
        chk("burst_valid_drop", bus.valid_out, 0);
        chk("burst_data_hold", bus.data_out, 16'h1);
        // back-to-back groups
        for (int g = 0; g < 2; g++) begin
            logic [W-1:0] b;
            b = (g == 0) ? 16'h10 : 16'h20;
            drive(1'b1, b, b + 16'd1, b + 16'd2, b + 16'd3);
            push(b, b + 16'd1, b + 16'd2, b + 16'd3);
            for (int k = 0; k < 4; k++) begin
                step();
                chk("b2b_valid", bus.valid_out, 1);
                if (k == 0) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
            end
        end
        step();
        chk("b2b_valid_drop", bus.valid_out, 0);
        // enable stall after second word
        drive(1'b1, 16'hA, 16'hB, 16'hC, 16'hD);
        push(16'hA, 16'hB, 16'hC, 16'hD);
        step();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        bus.enable = 1'b0;
        drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_data", bus.data_out, 16'hC);
            chk("stall_hold_valid", bus.valid_out, 1);
            chk("stall_hold_slot", bus.slot_out, 2);
        end
        bus.enable = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) step();
        chk("stall_valid_drop", bus.valid_out, 0);
`ifdef P4S1_OVERRUN_EN
        chk("stall_no_overrun", overrun, 0);
`endif
        // rejected load at cnt=2
        drive(1'b1, 16'h31, 16'h32, 16'h33, 16'h34);
        push(16'h31, 16'h32, 16'h33, 16'h34);
        step();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        chk("reject_ready_low", bus.ready, 0);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        chk("reject_valid_drop", bus.valid_out, 0);
        chk("reject_ready_back", bus.ready, 1);
`ifdef P4S1_OVERRUN_EN
        chk("overrun_set", overrun, 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("overrun_clear", overrun, 0);
`endif
        // asynchronous reset mid-burst
        drive(1'b1, 16'h41, 16'h42, 16'h43, 16'h44);
        push(16'h41, 16'h42, 16'h43, 16'h44);
        step();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        #1 rst = 1'b0;
        #1;
        chk("midrst_data", bus.data_out, 0);
        chk("midrst_valid", bus.valid_out, 0);
        chk("midrst_slot", bus.slot_out, 0);
        chk("midrst_ready", bus.ready, 1);
        sb.delete();
        step();
        rst = 1'b1;
        drive(1'b1, 16'h51, 16'h52, 16'h53, 16'h54);
        push(16'h51, 16'h52, 16'h53, 16'h54);
        step();
        chk("restart_slot", bus.slot_out, 3);
        chk("restart_data", bus.data_out, 16'h54);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (4) step();
        chk("restart_valid_drop", bus.valid_out, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/p4s1_burst.md
Name: p4s1_burst

Overview:
- 4-to-1 parallel-to-serial converter for the FFT-1024 radix-4 pipeline.
- Inverse of the 1-to-4 serial-to-parallel stage: captures four butterfly output words in one cycle and emits them one per enabled cycle on a single bus.
- Word order is chosen so that chaining the 1-to-4 stage into this block restores the original stream order.
- Emission order: data_in3 (oldest) first, data_in0 (newest) last.

Parameters:
- WORDLENGTH, 16, width of each data word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- enable  input  1  clock enable; no state changes while low.
- load  input  1  strobe: data_in0..3 valid this cycle.
- data_in0  input  WORDLENGTH  newest word of group.
- data_in1  input  WORDLENGTH  word 1.
- data_in2  input  WORDLENGTH  word 2.
- data_in3  input  WORDLENGTH  oldest word of group.
- ready  output  1  combinational; high when a load would be accepted this cycle.
- data_out  output  WORDLENGTH  registered serial word.
- valid_out  output  1  registered; data_out holds a valid word.
- slot_out  output  2  registered; index of the input word currently on data_out (3,2,1,0).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, cnt=0, shift register=0, data_out=0, valid_out=0, slot_out=0.
- States: IDLE, SHIFT. Internal cnt[1:0] counts words already emitted. Internal 3-word shift register sh holds the words not yet emitted.
- ready = (state==IDLE).
- All transitions below require enable==1. With enable==0, every register holds, including data_out, valid_out and slot_out. A load while enable==0 is ignored and is not an overrun.
- IDLE, load=1 (accept):
  - data_out<=data_in3, slot_out<=3, valid_out<=1.
  - sh<={data_in2,data_in1,data_in0}, cnt<=1, state<=SHIFT.
- IDLE, load=0: valid_out<=0; data_out and slot_out hold.
- SHIFT, each enabled edge: emit next word from sh (cnt=1 gives data_in2, cnt=2 gives data_in1, cnt=3 gives data_in0), slot_out<=3-cnt, valid_out<=1.
- SHIFT, cnt==3 edge: emit data_in0, then cnt<=0 (wrap) and state<=IDLE.
- SHIFT, load=1: not accepted. The load is dropped and the burst in progress continues unaffected.
- Latency: the first word appears on data_out one edge after acceptance; the last word appears 4 edges after acceptance.
- Back-to-back: load asserted every 4th enabled cycle (the cycle after the cnt==3 edge) gives continuous valid_out=1 with no bubble. Throughput is 1 word per enabled cycle.
- Data passes through unmodified: no arithmetic and no width change.
- A gap in enable mid-burst stretches the burst. Word order and count are unchanged.

Optional Feature:
- Macro: P4S1_OVERRUN_EN.
- Defined: adds ports clr_ovr (input, 1) and overrun (output, 1, registered, sticky).
  - Set when enable && load && !ready.
  - Cleared by reset or clr_ovr==1. If set and clear coincide, set wins.
- Undefined: neither port exists. Rejected loads are silently dropped. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0, drive load=1 with data -> data_out=0, valid_out=0, slot_out=0, ready=1; after release, outputs stay 0 until a load.
- Single burst: enable=1; at t0 load {in0..3}={0x0001,0x0002,0x0003,0x0004} -> data_out sequence 0x0004,0x0003,0x0002,0x0001 on edges t0+1..t0+4; slot_out 3,2,1,0; valid_out drops at t0+5.
- Back-to-back: loads every 4 cycles with groups {0x10..0x13} then {0x20..0x23} -> 8 contiguous valid words 0x13,0x12,0x11,0x10,0x23,0x22,0x21,0x20 with no valid_out gap.
- Enable stall: burst of {0xA,0xB,0xC,0xD}, enable=0 for 3 cycles after the 2nd word -> data_out holds 0xC for the stall; sequence completes 0xD,0xC,0xB,0xA.
- Rejected load: second load of 0xFFFF words during SHIFT cnt=2 -> ignored, current burst intact; with P4S1_OVERRUN_EN, overrun=1 until clr_ovr pulse.
- Mid-burst reset: assert rst during cnt=2 -> outputs 0 immediately (asynchronous); a new load after release starts cleanly at slot 3.
